sysid_boot_checker: RTL
=======================

Name: sysid_boot_checker

Overview:
- Avalon-MM master that reads the system ID peripheral: word 0 is the ID, word 1 is the timestamp.
- Compares both words against the values expected by software and raises pass/fail flags.
- Sits directly upstream of the sysid slave on the boot/control fabric. It gates release of downstream logic (MTL display and cube game engine) until the hardware image is confirmed.
- Includes a bounded-latency timeout so a missing or stalled slave cannot hang boot.

Parameters:
- EXP_ID, 32'd0, expected value at sysid address 0
- EXP_TS, 32'd1460600513, expected value at sysid address 1
- TIMEOUT_CYCLES, 255, maximum cycles per read transaction (waitrequest plus response) before abort; must be ≥1
- TO_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
- clock  in  1  single system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a check; ignored while busy
- avm_address  out  1  0 = ID word, 1 = timestamp word
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; request held while high
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data qualifier
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout)
- id_ok  out  1  last ID read equals EXP_ID
- ts_ok  out  1  last timestamp read equals EXP_TS
- timeout  out  1  last check aborted on timeout
- id_value  out  32  captured ID word
- ts_value  out  32  captured timestamp word

Behaviour:
- Reset: every output is 0, the state is IDLE and the timeout counter is 0.
- Reset asserted mid-transaction aborts the check immediately. No done pulse is produced and any pending readdatavalid is ignored afterwards.
- States: IDLE, REQ_ID, RSP_ID, REQ_TS, RSP_TS, FIN.
- IDLE: start=1 moves to REQ_ID. It also clears id_ok, ts_ok and timeout and sets busy, all on the same edge.
- REQ_ID: avm_read=1 and avm_address=0.
  - waitrequest=0 accepts the request and moves to RSP_ID. avm_read is driven low from the next cycle.
  - If readdatavalid arrives in the same cycle the request is accepted (zero-latency slave), capture it and go directly to REQ_TS.
- RSP_ID: readdatavalid=1 captures readdata into id_value, sets id_ok = (readdata == EXP_ID) and moves to REQ_TS.
- REQ_TS/RSP_TS: identical to REQ_ID/RSP_ID with avm_address=1. On capture, set ts_value and ts_ok, then move to FIN.
- FIN: done=1 and busy=0 for exactly one cycle, then IDLE.
- Address and read are held stable while waitrequest=1.
- Timeout counter:
  - Cleared on entry to each REQ state.
  - Increments every cycle spent in REQ or RSP states.
  - Reaching TIMEOUT_CYCLES sets timeout=1, drops avm_read and moves to FIN. The word not yet read keeps its _ok flag at 0.
  - If the counter hits the limit in the same cycle that data is captured, the data wins and timeout stays 0.
- start while busy or in FIN is dropped, not queued.
- id_ok, ts_ok, timeout, id_value and ts_value hold their values until the next start or reset.
- Latency with a zero-wait, one-cycle-response slave: start to done is 6 cycles.

Optional Feature:
- Macro: SYSID_BOOT_CHECKER_AUTOSTART_EN.
- Defined: an internal start is generated on the first cycle after reset deasserts, so exactly one check runs without software. The external start port remains functional.
- Undefined: checks run only on external start pulses.

Decomposition:
- Package sysid_boot_pkg:
  - state enum (IDLE..FIN)
  - address constants SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1
  - default EXP_ID/EXP_TS constants
- One sub-module, sysid_rd_timer: timeout counter with clear, enable and expired outputs.
- The FSM, capture and compare logic stay in the top module.

Test Plan:
- Match: slave returns 0 at address 0 and 1460600513 at address 1, with zero wait and 1-cycle readdatavalid. Pulse start → done 6 cycles later; id_ok=1, ts_ok=1, timeout=0.
- Wrong timestamp: slave returns 1460600514 → done; id_ok=1, ts_ok=0, ts_value=1460600514.
- Waitrequest stall: waitrequest held 10 cycles on the ID request → avm_address and avm_read stable throughout; done 16 cycles after start; both ok.
- Timeout: waitrequest stuck at 1 with TIMEOUT_CYCLES=255 → avm_read drops and FIN/done follow at count 255; timeout=1, id_ok=0, ts_ok=0; no timestamp request issued.
- Reset mid-check: assert reset during RSP_TS → all outputs 0 next cycle, no done pulse. A following start completes normally.
- Start while busy: a second start pulse during RSP_ID → exactly one done pulse results. With the macro defined, a check runs after reset with no start and done fires once.

Source files
------------

// File: rtl/sysid_boot_checker_pkg.sv
// Shared types and constants for the sysid boot checker: FSM states, the
// sysid word addresses and the image identity that software expects.
package sysid_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        RSP_ID,
        REQ_TS,
        RSP_TS,
        FIN
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_EXP_ID_DEFAULT = 32'd0;
    localparam logic [31:0] SYSID_EXP_TS_DEFAULT = 32'd1460600513;

endpackage

// File: rtl/sysid_boot_checker_rd_timer.sv
// Per-transaction watchdog for the sysid reads: counts cycles while enabled and
// flags the cycle on which the count reaches TIMEOUT_CYCLES.
module sysid_rd_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry marks the increment that lands on TIMEOUT_CYCLES.
    assign expired = enable && (count_q == LAST_COUNT);

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words, compares them
// with the expected image identity and reports pass/fail/timeout.
// Optional: define SYSID_BOOT_CHECKER_AUTOSTART_EN to run one check after reset.
module sysid_boot_checker
    import sysid_boot_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = SYSID_EXP_ID_DEFAULT,
    parameter logic [31:0] EXP_TS         = SYSID_EXP_TS_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          TO_W           = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_address_q, avm_address_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic start_req;
    logic tmr_clear;
    logic tmr_en;
    logic tmr_expired;
    logic in_req;
    logic is_ts;
    logic capture;

`ifdef SYSID_BOOT_CHECKER_AUTOSTART_EN
    // Held high through reset so the first free cycle afterwards launches a check.
    logic auto_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign start_req = start | auto_q;
`else
    assign start_req = start;
`endif

    sysid_rd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_rd_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_d     = timeout_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        tmr_clear     = 1'b0;
        tmr_en        = 1'b0;
        in_req        = (state_q == REQ_ID) || (state_q == REQ_TS);
        is_ts         = (state_q == REQ_TS) || (state_q == RSP_TS);
        capture       = avm_readdatavalid && (!in_req || !avm_waitrequest);

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d       = REQ_ID;
                    busy_d        = 1'b1;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_d     = 1'b0;
                    avm_read_d    = 1'b1;
                    avm_address_d = SYSID_ADDR_ID;
                    tmr_clear     = 1'b1;
                end
            end
            REQ_ID, RSP_ID, REQ_TS, RSP_TS: begin
                tmr_en = 1'b1;
                // Captured data takes priority over a simultaneous expiry.
                if (capture && !is_ts) begin
                    id_value_d    = avm_readdata;
                    id_ok_d       = (avm_readdata == EXP_ID);
                    state_d       = REQ_TS;
                    avm_read_d    = 1'b1;
                    avm_address_d = SYSID_ADDR_TS;
                    tmr_clear     = 1'b1;
                end else if (capture) begin
                    ts_value_d = avm_readdata;
                    ts_ok_d    = (avm_readdata == EXP_TS);
                    state_d    = FIN;
                    avm_read_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else if (tmr_expired) begin
                    timeout_d  = 1'b1;
                    state_d    = FIN;
                    avm_read_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else if (in_req && !avm_waitrequest) begin
                    state_d    = is_ts ? RSP_TS : RSP_ID;
                    avm_read_d = 1'b0;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule
